// File: rtl/fe_event_packer_if.sv
// ----------------------------------------------------------------------------
// fe_event_packer_if
// Bundles the capture-side event strobe, the flush control, the downstream
// word handshake and the status outputs of fe_event_packer.
//
//   I_fifo_wr       event strobe (one cycle per event)
//   I_fifo_command  event command
//   I_fifo_time     event timestamp
//   I_fifo_data     event payload byte
//   I_flush         synchronous discard of buffered and in-flight data
//   I_word_ready    downstream accepts O_word this cycle
//   O_word          packed output word
//   O_word_valid    O_word holds a valid word
//   O_overflow      sticky event-dropped flag
//   O_level         occupied buffer entries
//   O_idle          buffer empty and packer idle
//
// master: the environment (drives I_*, observes O_*)
// slave : the packer       (observes I_*, drives O_*)
// ----------------------------------------------------------------------------
interface fe_event_packer_if #(
   parameter int pDEPTH = 4
);
   logic                     I_fifo_wr;
   logic [1:0]               I_fifo_command;
   logic [15:0]              I_fifo_time;
   logic [7:0]               I_fifo_data;
   logic                     I_flush;
   logic                     I_word_ready;
   logic [17:0]              O_word;
   logic                     O_word_valid;
   logic                     O_overflow;
   logic [$clog2(pDEPTH):0]  O_level;
   logic                     O_idle;

   modport master (
      output I_fifo_wr, I_fifo_command, I_fifo_time, I_fifo_data,
      output I_flush, I_word_ready,
      input  O_word, O_word_valid, O_overflow, O_level, O_idle
   );

   modport slave (
      input  I_fifo_wr, I_fifo_command, I_fifo_time, I_fifo_data,
      input  I_flush, I_word_ready,
      output O_word, O_word_valid, O_overflow, O_level, O_idle
   );
endinterface

// File: rtl/fe_event_packer.sv
// ----------------------------------------------------------------------------
// fe_event_packer
// Buffers {command,time,data} events in a small circular buffer and packs
// each one into one or two 18-bit words for a downstream FIFO:
//   TIME  (command == pCMD_TIME)         : {pCMD_TIME, time}
//   SHORT (time fits in the short field) : {cmd, 1, time[short], pad, data}
//   LONG  (otherwise)                    : {pCMD_TIME, time} then
//                                          {cmd, 0, zeros, data}
//
// Ports
//   fe_clk     clock, all logic on the rising edge
//   reset_i    asynchronous active-high reset
//   bus        fe_event_packer_if.slave (event input, word output, status)
//   dbg_state  current packer FSM state
//
// Output handshake: a word transfers on every rising edge where
// O_word_valid=1 and I_word_ready=1. While O_word_valid=1 and
// I_word_ready=0, O_word and O_word_valid hold their values. O_word_valid
// never depends combinationally on I_word_ready.
//
// The head entry stays in the buffer (and in O_level) until its final word
// transfers; only then is it popped.
// ----------------------------------------------------------------------------
module fe_event_packer #(
   parameter int         pTIMESTAMP_SHORT_WIDTH = 3,
   parameter logic [1:0] pCMD_TIME              = 2'b10,
   parameter int         pDEPTH                 = 4
) (
   input  logic                fe_clk,
   input  logic                reset_i,
   fe_event_packer_if.slave    bus,
   output logic [1:0]          dbg_state
);

   localparam int PW  = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
   localparam int LW  = $clog2(pDEPTH) + 1;
   localparam int SW  = pTIMESTAMP_SHORT_WIDTH;
   localparam int PAD = 7 - SW;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EMIT_TIME = 2'd1,
      EMIT_DATA = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      cmd_mem  [pDEPTH];
   logic [15:0]     time_mem [pDEPTH];
   logic [7:0]      data_mem [pDEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
   logic [LW-1:0]   level;
   logic [17:0]     word_q, word_nxt;
   logic            valid_q, valid_nxt;
   logic            overflow_q;
   logic            full, push, pop;

   function automatic logic is_long(input logic [1:0] c, input logic [15:0] t);
      return (c != pCMD_TIME) && ((t >> SW) != 16'd0);
   endfunction

   // First word of an event: TIME and LONG events both start with a
   // timestamp word.
   function automatic logic [17:0] first_word(input logic [1:0] c,
                                              input logic [15:0] t,
                                              input logic [7:0] d);
      if (c == pCMD_TIME || is_long(c, t))
         return {pCMD_TIME, t};
      else
         return {c, 1'b1, t[SW-1:0], {PAD{1'b0}}, d};
   endfunction

   function automatic logic [17:0] data_word(input logic [1:0] c,
                                             input logic [7:0] d);
      return {c, 1'b0, 7'd0, d};
   endfunction

   assign full        = (level == LW'(pDEPTH));
   // Flush wins over a same-cycle write; a full buffer drops the write even
   // if the head is popped in the same cycle.
   assign push        = bus.I_fifo_wr && !full && !bus.I_flush;
   assign rd_ptr_next = rd_ptr + 1'b1;

   // ---------------- buffer storage (no reset needed) ----------------------
   always_ff @(posedge fe_clk) begin
      if (push) begin
         cmd_mem[wr_ptr]  <= bus.I_fifo_command;
         time_mem[wr_ptr] <= bus.I_fifo_time;
         data_mem[wr_ptr] <= bus.I_fifo_data;
      end
   end

   // ---------------- pointers, level, overflow -----------------------------
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow_q <= 1'b0;
      end else if (bus.I_flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr_next;
         level <= level + LW'(push) - LW'(pop);
         if (bus.I_fifo_wr && full)
            overflow_q <= 1'b1;
      end
   end

   // ---------------- FSM state and output register -------------------------
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state   <= IDLE;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         word_q  <= word_nxt;
         valid_q <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word_q;
      valid_nxt = valid_q;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               word_nxt  = first_word(cmd_mem[rd_ptr], time_mem[rd_ptr],
                                      data_mem[rd_ptr]);
               valid_nxt = 1'b1;
               state_nxt = is_long(cmd_mem[rd_ptr], time_mem[rd_ptr])
                           ? EMIT_TIME : EMIT_DATA;
            end
         end
         EMIT_TIME: begin
            if (bus.I_word_ready) begin
               word_nxt  = data_word(cmd_mem[rd_ptr], data_mem[rd_ptr]);
               state_nxt = EMIT_DATA;
            end
         end
         EMIT_DATA: begin
            if (bus.I_word_ready) begin
               pop = 1'b1;
               // Only entries already stored count; a write arriving this
               // cycle is picked up from IDLE on the next cycle.
               if (level > LW'(1)) begin
                  word_nxt  = first_word(cmd_mem[rd_ptr_next],
                                         time_mem[rd_ptr_next],
                                         data_mem[rd_ptr_next]);
                  state_nxt = is_long(cmd_mem[rd_ptr_next],
                                      time_mem[rd_ptr_next])
                              ? EMIT_TIME : EMIT_DATA;
               end else begin
                  valid_nxt = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
      if (bus.I_flush) begin
         pop       = 1'b0;
         valid_nxt = 1'b0;
         state_nxt = IDLE;
      end
   end

   assign bus.O_word       = word_q;
   assign bus.O_word_valid = valid_q;
   assign bus.O_overflow   = overflow_q;
   assign bus.O_level      = level;
   assign bus.O_idle       = (level == '0) && (state == IDLE);
   assign dbg_state        = state;

endmodule

// File: doc/fe_event_packer.md
FE_EVENT_PACKER -- requirements
Module: fe_event_packer

Interface
REQ-001 SHALL have parameter pTIMESTAMP_SHORT_WIDTH, default 3, the number of timestamp bits carried inline in a data word.
REQ-002 SHALL have parameter pCMD_TIME, default 2'b10, the command code of a standalone timestamp word.
REQ-003 SHALL have parameter pDEPTH, default 4, the input buffer depth in entries (power of two).
REQ-004 fe_clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset_i  input  1  reset, asynchronous and active-high.
REQ-006 I_fifo_wr  input  1  one-cycle event strobe from the capture stage.
REQ-007 I_fifo_command  input  2  event command.
REQ-008 I_fifo_time  input  16  event timestamp.
REQ-009 I_fifo_data  input  8  event payload byte.
REQ-010 I_flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-011 I_word_ready  input  1  downstream FIFO accepts O_word this cycle.
REQ-012 O_word  output  18  packed output word.
REQ-013 O_word_valid  output  1  O_word holds a valid word.
REQ-014 O_overflow  output  1  sticky flag: an event was dropped.
REQ-015 O_level  output  log2(pDEPTH)+1  number of occupied buffer entries.
REQ-016 O_idle  output  1  high when the buffer is empty and the FSM is in IDLE.

Function
REQ-017 SHALL capture {command,time,data} into a pDEPTH-entry circular buffer on each cycle where I_fifo_wr=1 and O_level<pDEPTH.
REQ-018 SHALL drop the event and set O_overflow when I_fifo_wr=1 and O_level==pDEPTH, including when a pop occurs in the same cycle.
REQ-019 SHALL hold O_overflow at 1 until reset_i or I_flush.
REQ-020 SHALL classify the buffer head as: TIME when command==pCMD_TIME; SHORT when time < 2**pTIMESTAMP_SHORT_WIDTH; LONG otherwise.
REQ-021 TIME word format SHALL be {pCMD_TIME, time[15:0]}.
REQ-022 SHORT word format SHALL be {cmd, 1'b1, time[pTIMESTAMP_SHORT_WIDTH-1:0], zero pad, data[7:0]}.
REQ-023 LONG SHALL emit two words in order: a TIME word {pCMD_TIME, time} followed by the data word {cmd, 1'b0, zeros, data}.
REQ-024 The FSM SHALL have states IDLE, EMIT_TIME and EMIT_DATA.
REQ-025 IDLE: when the buffer is non-empty, load the head into the output register and go to EMIT_TIME if LONG, else to EMIT_DATA.
REQ-026 EMIT_TIME: assert valid with the TIME word; on I_word_ready load the data word and go to EMIT_DATA.
REQ-027 EMIT_DATA: assert valid; on I_word_ready pop the head; if a further entry exists, load it directly (no bubble cycle); otherwise go to IDLE.
REQ-028 SHALL hold O_word and O_word_valid stable while O_word_valid=1 and I_word_ready=0.
REQ-029 Latency: an event written in cycle N SHALL have its first word valid in cycle N+2 when the buffer and FSM are idle.
REQ-030 Sustained throughput SHALL be 1 SHORT or TIME event per cycle, or 1 LONG event per 2 cycles, with I_word_ready held high.
REQ-031 A simultaneous write and pop with the buffer not full SHALL leave O_level unchanged.
REQ-032 Read and write pointers SHALL wrap modulo pDEPTH.
REQ-033 I_flush SHALL, on the next edge, empty the buffer, clear O_overflow, return the FSM to IDLE and deassert O_word_valid.
REQ-034 I_flush SHALL take priority over an I_fifo_wr arriving in the same cycle; that event is discarded and does not set O_overflow.

Reset
REQ-035 reset_i SHALL asynchronously set O_word=0, O_word_valid=0, O_overflow=0, O_level=0, O_idle=1, pointers=0 and FSM=IDLE.
REQ-036 Reset asserted mid-packet SHALL abandon the packet; no partial word SHALL be presented after release.
REQ-037 Leaving reset SHALL require no idle cycles before the first write is accepted.

Verification
REQ-038 Event cmd=01, time=5, data=A5, ready=1 -> single word {01,1,101,0000,A5h} valid 2 cycles later; O_idle returns to 1.
REQ-039 Event cmd=00, time=0x1234, data=3C -> words {10,1234h} then {00,0,000,0000,3Ch} on consecutive cycles.
REQ-040 Five back-to-back writes with ready=0 -> O_level=4, fifth event dropped, O_overflow=1; raising ready drains exactly 4 events in order.
REQ-041 ready toggling 1/0 during LONG emission -> O_word held while stalled; no word lost or duplicated.
REQ-042 I_flush asserted with 3 entries buffered while in EMIT_TIME -> O_level=0, O_word_valid=0 and O_overflow=0 next cycle.
REQ-043 reset_i pulsed asynchronously between edges mid-LONG -> outputs go to reset values immediately; 6 wraps of 4 events afterwards deliver correct order.
